// File: rtl/cu_seq_pkg.sv
// -----------------------------------------------------------------------------
// cu_seq_pkg
// Shared definitions for the control-unit step sequencer:
//   - seq_state_e : sequencer FSM states (RUN / HALT)
//   - CU_STEP_W   : default step counter width
//   - CU_T_PER_M  : default T-cycles per M-cycle
//   - cu_t_w()    : width of the T-cycle counter for a given T_PER_M
// No ports (package).
// -----------------------------------------------------------------------------
package cu_seq_pkg;

  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_state_e;

  localparam int CU_STEP_W  = 5;
  localparam int CU_T_PER_M = 4;

  // Width needed to count 0..t_per_m-1, never less than one bit so the
  // T-cycle output always exists (T_PER_M = 1 gives a constant-0 bit).
  function automatic int cu_t_w(input int t_per_m);
    return (t_per_m <= 2) ? 1 : $clog2(t_per_m);
  endfunction

endpackage

// File: rtl/cu_tcycle_counter.sv
// -----------------------------------------------------------------------------
// cu_tcycle_counter
// Modulo-T_PER_M counter tracking the T-cycle inside the current M-cycle.
// Ports:
//   i_Clk     in   system clock
//   i_Reset   in   synchronous active-high reset (counter -> 0)
//   i_Adv     in   advance by one T-cycle this clock
//   o_TCycle  out  current T-cycle (registered)
//   o_LastT   out  high while o_TCycle is the last T-cycle of the M-cycle
// -----------------------------------------------------------------------------
module cu_tcycle_counter
  import cu_seq_pkg::*;
#(
  parameter int T_PER_M = CU_T_PER_M,
  localparam int T_W = cu_t_w(T_PER_M)
) (
  input  logic           i_Clk,
  input  logic           i_Reset,
  input  logic           i_Adv,
  output logic [T_W-1:0] o_TCycle,
  output logic           o_LastT
);

  localparam logic [T_W-1:0] LAST_T = T_W'(T_PER_M - 1);

  logic [T_W-1:0] tcycle_q;

  // With T_PER_M = 1, LAST_T is 0 so the counter never leaves 0 and every
  // cycle is the last T-cycle.
  assign o_LastT  = (tcycle_q == LAST_T);
  assign o_TCycle = tcycle_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      tcycle_q <= '0;
    end else if (i_Adv) begin
      tcycle_q <= o_LastT ? '0 : tcycle_q + T_W'(1);
    end
  end

endmodule

// File: rtl/cu_step_sequencer.sv
// -----------------------------------------------------------------------------
// cu_step_sequencer
// Control-unit step sequencer: tracks the T-cycle within each M-cycle and the
// M-cycle step within the current instruction. Supports wait-state stalls,
// step jumps, early end-of-instruction and HALT/wake. Requests (load, end,
// halt) are latched and consumed at the next M-cycle boundary.
//
// Optional feature macro: CU_SEQ_RANGE_CHECK_EN
//   defined   : load targets above MAX_STEP are clamped to MAX_STEP and the
//               sticky o_RangeErr output is present.
//   undefined : out-of-range targets load unchanged; no o_RangeErr port.
//
// Ports:
//   i_Clk          in   system clock
//   i_Reset        in   synchronous active-high reset, overrides all inputs
//   i_Enable       in   counters advance only while high
//   i_Stall        in   wait state, freezes counters
//   i_Load         in   jump to i_LoadStep at next M-cycle boundary
//   i_LoadStep     in   jump target
//   i_EndInstr     in   restart at step 0 at next M-cycle boundary
//   i_Halt         in   enter HALT at next M-cycle boundary
//   i_Wake         in   leave HALT
//   o_Step         out  current M-cycle step (registered)
//   o_TCycle       out  current T-cycle (registered)
//   o_MCycleStart  out  RUN and T-cycle 0
//   o_MCycleEnd    out  RUN, last T-cycle and advancing this clock
//   o_Wrap         out  pulse the cycle after a natural wrap to step 0
//   o_Halted       out  FSM is in HALT (direct decode of the state register)
//   o_RangeErr     out  (feature only) sticky clamped-load flag
// -----------------------------------------------------------------------------
module cu_step_sequencer
  import cu_seq_pkg::*;
#(
  parameter int STEP_W   = CU_STEP_W,
  parameter int MAX_STEP = 31,
  parameter int T_PER_M  = CU_T_PER_M,
  localparam int T_W = cu_t_w(T_PER_M)
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Enable,
  input  logic              i_Stall,
  input  logic              i_Load,
  input  logic [STEP_W-1:0] i_LoadStep,
  input  logic              i_EndInstr,
  input  logic              i_Halt,
  input  logic              i_Wake,
  output logic [STEP_W-1:0] o_Step,
  output logic [T_W-1:0]    o_TCycle,
  output logic              o_MCycleStart,
  output logic              o_MCycleEnd,
  output logic              o_Wrap,
  output logic              o_Halted
`ifdef CU_SEQ_RANGE_CHECK_EN
  ,
  output logic              o_RangeErr
`endif
);

  localparam logic [STEP_W-1:0] MAX_V = STEP_W'(MAX_STEP);

  seq_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              wrap_q, wrap_d;

  logic              pend_load_q, pend_load_d;
  logic              pend_end_q, pend_end_d;
  logic              pend_halt_q, pend_halt_d;
  logic [STEP_W-1:0] pend_step_q, pend_step_d;

  logic              run;
  logic              adv;
  logic              last_t;
  logic              mcycle_end;
  logic              eff_load;
  logic              eff_end;
  logic              eff_halt;
  logic [STEP_W-1:0] eff_target;
  logic [STEP_W-1:0] load_val;
  logic              at_top;

  assign run = (state_q == SEQ_RUN);
  assign adv = run & i_Enable & ~i_Stall;

  cu_tcycle_counter #(
    .T_PER_M (T_PER_M)
  ) u_tcycle (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Adv    (adv),
    .o_TCycle (o_TCycle),
    .o_LastT  (last_t)
  );

  // A stall on the last T-cycle suppresses the boundary, so pendings survive
  // until the counters actually move.
  assign mcycle_end = adv & last_t;

  // Requests arriving on the boundary cycle itself are consumed immediately;
  // a live i_Load takes precedence over an older latched target.
  assign eff_load   = pend_load_q | i_Load;
  assign eff_end    = pend_end_q  | i_EndInstr;
  assign eff_halt   = pend_halt_q | i_Halt;
  assign eff_target = i_Load ? i_LoadStep : pend_step_q;

  // The all-ones check catches steps above MAX_STEP reached by an unclamped
  // load, so the counter still wraps instead of overflowing silently.
  assign at_top = (step_q == MAX_V) || (step_q == '1);

`ifdef CU_SEQ_RANGE_CHECK_EN
  logic clamp;
  logic range_set;
  logic range_err_q;

  assign clamp      = (eff_target > MAX_V);
  assign load_val   = clamp ? MAX_V : eff_target;
  assign o_RangeErr = range_err_q;
`else
  assign load_val = eff_target;
`endif

  // Next-state, next-step and pending-request logic.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    wrap_d      = 1'b0;
    pend_load_d = pend_load_q;
    pend_end_d  = pend_end_q;
    pend_halt_d = pend_halt_q;
    pend_step_d = pend_step_q;
`ifdef CU_SEQ_RANGE_CHECK_EN
    range_set   = 1'b0;
`endif
    case (state_q)
      SEQ_RUN: begin
        if (mcycle_end) begin
          pend_load_d = 1'b0;
          pend_end_d  = 1'b0;
          pend_halt_d = 1'b0;
          if (eff_halt) begin
            state_d = SEQ_HALT;
            step_d  = '0;
          end else if (eff_end) begin
            step_d = '0;
          end else if (eff_load) begin
            step_d = load_val;
`ifdef CU_SEQ_RANGE_CHECK_EN
            range_set = clamp;
`endif
          end else if (at_top) begin
            step_d = '0;
            wrap_d = 1'b1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end else begin
          if (i_Load) begin
            pend_load_d = 1'b1;
            pend_step_d = i_LoadStep;
          end
          if (i_EndInstr) pend_end_d  = 1'b1;
          if (i_Halt)     pend_halt_d = 1'b1;
        end
      end
      SEQ_HALT: begin
        // Requests are not latched while halted; the step is held at 0.
        step_d      = '0;
        pend_load_d = 1'b0;
        pend_end_d  = 1'b0;
        pend_halt_d = 1'b0;
        if (i_Wake) state_d = SEQ_RUN;
      end
      default: begin
        state_d = SEQ_RUN;
        step_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= SEQ_RUN;
      step_q      <= '0;
      wrap_q      <= 1'b0;
      pend_load_q <= 1'b0;
      pend_end_q  <= 1'b0;
      pend_halt_q <= 1'b0;
      pend_step_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      wrap_q      <= wrap_d;
      pend_load_q <= pend_load_d;
      pend_end_q  <= pend_end_d;
      pend_halt_q <= pend_halt_d;
      pend_step_q <= pend_step_d;
    end
  end

`ifdef CU_SEQ_RANGE_CHECK_EN
  // Sticky: set on the edge the clamped step is loaded, cleared only by reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      range_err_q <= 1'b0;
    end else if (range_set) begin
      range_err_q <= 1'b1;
    end
  end
`endif

  assign o_Step        = step_q;
  assign o_Wrap        = wrap_q;
  assign o_MCycleStart = run & (o_TCycle == '0);
  assign o_MCycleEnd   = mcycle_end;
  assign o_Halted      = (state_q == SEQ_HALT);

endmodule
